flash_read_seq: RTL and testbench

- Parametrised digital read sequencer for the NAND-style flash test arrays in the user project area. Generalises the fixed 8x8 hookup, where the array's sense and output-enable pins are wired straight to pads.
- Drives row select, the two sense-enable phases (precharge, evaluate) and per-group output enables with programmable timing. Captures the array's digital sense outputs and returns one word per row over a valid/ready stream.
- Supports multi-row bursts with row wrap-around, backpressure and abort.
- Sits between LA/Wishbone-side control logic and the array macro.

---
 rtl/flash_read_seq_pkg.sv | 39 +++
 rtl/flash_read_seq_timer.sv | 32 +++
 rtl/flash_read_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_flash_read_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/flash_read_seq_pkg.sv
// Shared types, default timing and helpers for the flash read sequencer.
// Define FLASH_READ_SEQ_MAJORITY_EN to sense every row three times and vote.
package flash_read_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_EVAL  = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int DEF_ROWS      = 8;
  localparam int DEF_COLS      = 8;
  localparam int DEF_GROUPS    = 4;
  localparam int DEF_T_PRE     = 4;
  localparam int DEF_T_EVAL    = 8;
  localparam int DEF_MAX_BURST = 8;

  // Helpers work on a wide vector; callers size-cast to ROWS/COLS (both <= 64).
  localparam int VEC_W = 64;

`ifdef FLASH_READ_SEQ_MAJORITY_EN
  localparam int N_PASS = 3;
`else
  localparam int N_PASS = 1;
`endif

  function automatic logic [VEC_W-1:0] onehot(input logic [5:0] idx);
    onehot = 64'd1 << idx;
  endfunction

  function automatic logic [VEC_W-1:0] majority3(input logic [VEC_W-1:0] a,
                                                 input logic [VEC_W-1:0] b,
                                                 input logic [VEC_W-1:0] c);
    majority3 = (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/flash_read_seq_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded interval.
module flash_read_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Count the loaded interval down to zero and park there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - W'(1);
    end
  end

  assign cnt  = cnt_r;
  assign done = (cnt_r == W'(1));

endmodule

// File: rtl/flash_read_seq.sv
// Read sequencer for the NAND-style flash test array: precharge, evaluate, group latch, stream out.
// Define FLASH_READ_SEQ_MAJORITY_EN for triple-pass majority-voted sensing.
module flash_read_seq
  import flash_read_seq_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int GROUPS    = DEF_GROUPS,
  parameter int T_PRE     = DEF_T_PRE,
  parameter int T_EVAL    = DEF_T_EVAL,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(ROWS)-1:0]      req_row,
  input  logic [$clog2(MAX_BURST)-1:0] req_len,
  input  logic                         abort,
  output logic [ROWS-1:0]              wl_sel,
  output logic                         sen1,
  output logic                         sen2,
  output logic [GROUPS-1:0]            out_en,
  input  logic [COLS-1:0]              sense_in,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [COLS-1:0]              rd_data,
  output logic [$clog2(ROWS)-1:0]      rd_row,
  output logic                         rd_last,
  output logic                         busy
);

  localparam int RW   = $clog2(ROWS);
  localparam int LW   = $clog2(MAX_BURST);
  localparam int SW   = COLS / GROUPS;
  localparam int TMAX = (T_PRE > T_EVAL) ? ((T_PRE > GROUPS) ? T_PRE : GROUPS)
                                         : ((T_EVAL > GROUPS) ? T_EVAL : GROUPS);
  localparam int TW   = $clog2(TMAX + 1);

  state_t          state_r;
  logic [RW-1:0]   row_r;
  logic [LW-1:0]   remain_r;
  logic [1:0]      pass_r;
  logic [COLS-1:0] cap_r [N_PASS];

  logic            accept_s;
  logic            hs_s;
  logic            final_pass_s;
  logic [RW-1:0]   row_next_s;
  logic [COLS-1:0] cap_sel_s;
  logic [COLS-1:0] cap_ins_s;
  logic [COLS-1:0] word_s;
  logic            tmr_load_s;
  logic [TW-1:0]   tmr_val_s;
  logic [TW-1:0]   tmr_cnt_s;
  logic            tmr_done_s;

  assign accept_s     = (state_r == ST_IDLE) && req_valid && req_ready && !abort;
  assign hs_s         = (state_r == ST_HOLD) && rd_valid && rd_ready;
  assign final_pass_s = (pass_r == 2'(N_PASS - 1));
  assign row_next_s   = (row_r == RW'(ROWS - 1)) ? {RW{1'b0}} : row_r + RW'(1);

  flash_read_seq_timer #(.W(TW)) u_timer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .clr      (abort),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .cnt      (tmr_cnt_s),
    .done     (tmr_done_s)
  );

  // Select the timer interval for the phase being entered.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = TW'(T_PRE);
    if (abort) begin
      tmr_load_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:  tmr_load_s = accept_s;
        ST_PRE: begin
          tmr_load_s = tmr_done_s;
          tmr_val_s  = TW'(T_EVAL);
        end
        ST_EVAL: begin
          tmr_load_s = tmr_done_s;
          tmr_val_s  = TW'(GROUPS);
        end
        ST_LATCH: tmr_load_s = tmr_done_s && !final_pass_s;
        ST_HOLD:  tmr_load_s = hs_s && (remain_r != {LW{1'b0}});
        default:  tmr_load_s = 1'b0;
      endcase
    end
  end

  // Merge the currently enabled column group into this pass's capture word.
  always_comb begin
    int grp_i;
    grp_i     = 0;
    cap_sel_s = {COLS{1'b0}};
    for (int p = 0; p < N_PASS; p++) begin
      if (pass_r == 2'(p)) begin
        cap_sel_s = cap_r[p];
      end else begin
        cap_sel_s = cap_sel_s;
      end
    end
    // Timer holds GROUPS..1 during LATCH, so group index is GROUPS - count.
    if ((state_r == ST_LATCH) && (tmr_cnt_s != {TW{1'b0}}) && (int'(tmr_cnt_s) <= GROUPS)) begin
      grp_i = GROUPS - int'(tmr_cnt_s);
    end else begin
      grp_i = 0;
    end
    cap_ins_s = cap_sel_s;
    cap_ins_s[grp_i*SW +: SW] = sense_in[grp_i*SW +: SW];
  end

`ifdef FLASH_READ_SEQ_MAJORITY_EN
  assign word_s = COLS'(majority3(VEC_W'(cap_r[0]), VEC_W'(cap_r[1]), VEC_W'(cap_ins_s)));
`else
  assign word_s = cap_ins_s;
`endif

  // Sequencer state, array strobes and read-stream outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r   <= ST_IDLE;
      row_r     <= {RW{1'b0}};
      remain_r  <= {LW{1'b0}};
      pass_r    <= 2'd0;
      for (int p = 0; p < N_PASS; p++) cap_r[p] <= {COLS{1'b0}};
      req_ready <= 1'b0;
      busy      <= 1'b0;
      wl_sel    <= {ROWS{1'b0}};
      sen1      <= 1'b0;
      sen2      <= 1'b0;
      out_en    <= {GROUPS{1'b0}};
      rd_valid  <= 1'b0;
      rd_data   <= {COLS{1'b0}};
      rd_row    <= {RW{1'b0}};
      rd_last   <= 1'b0;
    end else if (abort) begin
      state_r   <= ST_IDLE;
      pass_r    <= 2'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      wl_sel    <= {ROWS{1'b0}};
      sen1      <= 1'b0;
      sen2      <= 1'b0;
      out_en    <= {GROUPS{1'b0}};
      rd_valid  <= 1'b0;
      rd_data   <= {COLS{1'b0}};
      rd_row    <= {RW{1'b0}};
      rd_last   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_PRE;
            row_r     <= req_row;
            remain_r  <= req_len;
            pass_r    <= 2'd0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            wl_sel    <= ROWS'(onehot(6'(req_row)));
            sen1      <= 1'b1;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_PRE: begin
          if (tmr_done_s) begin
            state_r <= ST_EVAL;
            sen1    <= 1'b0;
            sen2    <= 1'b1;
          end
        end
        ST_EVAL: begin
          if (tmr_done_s) begin
            state_r <= ST_LATCH;
            out_en  <= GROUPS'(1);
          end
        end
        ST_LATCH: begin
          for (int p = 0; p < N_PASS; p++) begin
            if (pass_r == 2'(p)) cap_r[p] <= cap_ins_s;
          end
          if (tmr_done_s) begin
            out_en <= {GROUPS{1'b0}};
            sen2   <= 1'b0;
            if (final_pass_s) begin
              state_r  <= ST_HOLD;
              wl_sel   <= {ROWS{1'b0}};
              rd_valid <= 1'b1;
              rd_data  <= word_s;
              rd_row   <= row_r;
              rd_last  <= (remain_r == {LW{1'b0}});
            end else begin
              state_r <= ST_PRE;
              pass_r  <= pass_r + 2'd1;
              sen1    <= 1'b1;
            end
          end else begin
            out_en <= out_en << 1;
          end
        end
        ST_HOLD: begin
          if (hs_s) begin
            rd_valid <= 1'b0;
            rd_data  <= {COLS{1'b0}};
            rd_row   <= {RW{1'b0}};
            rd_last  <= 1'b0;
            if (remain_r == {LW{1'b0}}) begin
              state_r   <= ST_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state_r  <= ST_PRE;
              row_r    <= row_next_s;
              remain_r <= remain_r - LW'(1);
              pass_r   <= 2'd0;
              wl_sel   <= ROWS'(onehot(6'(row_next_s)));
              sen1     <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          wl_sel    <= {ROWS{1'b0}};
          sen1      <= 1'b0;
          sen2      <= 1'b0;
          out_en    <= {GROUPS{1'b0}};
          rd_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_seq.sv
// Self-checking bench for flash_read_seq: array model, directed and randomized bursts.
module tb_flash_read_seq;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int GROUPS = 4;
  localparam int T_PRE  = 4;
  localparam int T_EVAL = 8;
  localparam int SW     = COLS / GROUPS;
`ifdef FLASH_READ_SEQ_MAJORITY_EN
  localparam int NP = 3;
`else
  localparam int NP = 1;
`endif
  localparam int ROW_CYC = T_PRE + T_EVAL + GROUPS;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_row = 3'd0;
  logic [2:0]        req_len = 3'd0;
  logic              abort = 1'b0;
  logic [ROWS-1:0]   wl_sel;
  logic              sen1;
  logic              sen2;
  logic [GROUPS-1:0] out_en;
  logic [COLS-1:0]   sense_in;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [COLS-1:0]   rd_data;
  logic [2:0]        rd_row;
  logic              rd_last;
  logic              busy;

  logic [COLS-1:0]   mem [ROWS];
  logic              force_en = 1'b0;
  logic [COLS-1:0]   force_val = 8'h00;
  int                checks = 0;
  int                errors = 0;

  flash_read_seq dut (
    .wb_clk_i (wb_clk_i), .wb_rst_n (wb_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row), .req_len(req_len),
    .abort    (abort),
    .wl_sel   (wl_sel), .sen1(sen1), .sen2(sen2), .out_en(out_en), .sense_in(sense_in),
    .rd_valid (rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_row(rd_row),
    .rd_last  (rd_last), .busy(busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Array model: enabled groups show the stored word, disabled groups show its complement.
  always_comb begin
    sense_in = 8'h00;
    for (int r = 0; r < ROWS; r++) begin
      if (wl_sel[r]) begin
        for (int g = 0; g < GROUPS; g++) begin
          sense_in[g*SW +: SW] = out_en[g] ? mem[r][g*SW +: SW] : ~mem[r][g*SW +: SW];
        end
      end
    end
    if (force_en) sense_in = force_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [14:0] pins();
    return {wl_sel, sen1, sen2, out_en, rd_valid};
  endfunction

  // Expected strobes c cycles into a row (c=1 is the first precharge cycle).
  function automatic logic [14:0] exp_pins(input int row, input int c);
    int         ph;
    logic [7:0] w;
    logic [3:0] oe;
    ph = (c - 1) % ROW_CYC + 1;
    w  = 8'd1 << row;
    oe = (ph > T_PRE + T_EVAL) ? (4'd1 << (ph - T_PRE - T_EVAL - 1)) : 4'd0;
    return {w, 1'(ph <= T_PRE), 1'(ph > T_PRE), oe, 1'b0};
  endfunction

  task automatic do_read(input int row, input int len, input int stall0, input bit rnd_stall);
    int r;
    int stall;
    req_row   = 3'(row);
    req_len   = 3'(len);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("accept_busy", 32'({busy, req_ready}), 32'(2'b10));
    for (int i = 0; i <= len; i++) begin
      r = (row + i) % ROWS;
      for (int c = 1; c <= NP * ROW_CYC; c++) begin
        check("phase", 32'(pins()), 32'(exp_pins(r, c)));
        req_valid = 1'($urandom_range(0, 1));
        req_row   = 3'($urandom);
        req_len   = 3'($urandom);
        tick();
      end
      req_valid = 1'b0;
      check("hold_pins", 32'(pins()), 32'(15'd1));
      check("rd_data", 32'(rd_data), 32'(mem[r]));
      check("rd_row", 32'(rd_row), 32'(r));
      check("rd_last", 32'(rd_last), 32'(i == len));
      check("hold_busy", 32'({busy, req_ready}), 32'(2'b10));
      stall = (i == 0) ? stall0 : (rnd_stall ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s < stall; s++) begin
        tick();
        check("stall_stable", 32'({pins(), rd_data}), 32'({15'd1, mem[r]}));
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    check("done_idle", 32'({busy, req_ready, rd_valid}), 32'(3'b010));
    tick();
    check("not_queued", 32'({busy, sen1}), 32'(2'b00));
  endtask

  initial begin
    int seen;
    for (int r = 0; r < ROWS; r++) mem[r] = 8'($urandom);
    mem[3] = 8'hA5;

    // Reset state
    #2 wb_rst_n = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("reset_outs", 32'({pins(), rd_data, busy, req_ready, rd_last}), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    tick();
    tick();
    check("reset_idle", 32'({busy, req_ready}), 32'(2'b01));

    // Single read, burst wrap, backpressure, random bursts
    do_read(3, 0, 0, 1'b0);
    do_read(6, 2, 0, 1'b0);
    do_read(int'($urandom_range(0, ROWS - 1)), 1, 10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      do_read(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), 1'b1);
    end

    // Abort during EVAL
    req_row = 3'd2; req_len = 3'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (T_PRE + 2) tick();
    check("pre_abort_eval", 32'({sen1, sen2}), 32'(2'b01));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outs", 32'({pins(), rd_data, rd_last, busy, req_ready}), 32'd1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (rd_valid || busy) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);

    // Abort together with req_valid in IDLE
    req_valid = 1'b1; abort = 1'b1;
    tick();
    req_valid = 1'b0; abort = 1'b0;
    check("abort_idle", 32'({busy, req_ready, wl_sel, sen1}), 32'({1'b0, 1'b1, 8'd0, 1'b0}));
    tick();
    check("abort_idle2", 32'({busy, sen1}), 32'(2'b00));

    // Async reset mid-LATCH, between clock edges
    req_row = 3'd5; req_len = 3'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (T_PRE + T_EVAL + 1) tick();
    check("latch_g1", 32'(out_en), 32'(4'b0010));
    #2 wb_rst_n = 1'b0;
    #1;
    check("async_reset", 32'({pins(), rd_data, busy, req_ready}), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    tick();
    tick();
    do_read(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, 3)), 2, 1'b1);

`ifdef FLASH_READ_SEQ_MAJORITY_EN
    // Majority vote across three passes with a corrupted middle pass
    force_en = 1'b1; force_val = 8'hA5;
    req_row = 3'd1; req_len = 3'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (ROW_CYC) tick();
    force_val = 8'hFF;
    repeat (ROW_CYC) tick();
    force_val = 8'hA5;
    repeat (ROW_CYC - 1) tick();
    check("maj_lat_early", 32'(rd_valid), 32'd0);
    tick();
    check("maj_word", 32'({rd_valid, rd_data}), 32'({1'b1, 8'hA5}));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    force_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
